// File: rtl/fifo_sync_flags_pkg.sv
// Shared constants, types and helpers for the parametrised synchronous FIFO.
// Holds the default geometry, the read-mode selectors and the address-width helper.
package fifo_sync_flags_pkg;

  localparam int unsigned DEFAULT_WIDTH = 6;
  localparam int unsigned DEFAULT_DEPTH = 32;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // Encoding matches {write_accepted, read_accepted}.
  typedef enum logic [1:0] {
    AccNone  = 2'b00,
    AccRead  = 2'b01,
    AccWrite = 2'b10,
    AccBoth  = 2'b11
  } acc_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer handshake bundle for fifo_sync_flags.
// The master modport is the user side; the slave modport is the FIFO itself.
interface fifo_sync_flags_if
  import fifo_sync_flags_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
);

  localparam int unsigned AW = addr_width(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      level;
  logic             overflow;
  logic             underflow;
  logic             clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem
  import fifo_sync_flags_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW   = addr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_flags.sv
// Parametrised synchronous FIFO with registered occupancy flags, sticky error flags
// and a selectable standard / first-word-fall-through read mode.
module fifo_sync_flags
  import fifo_sync_flags_pkg::*;
#(
  parameter int unsigned WIDTH         = DEFAULT_WIDTH,
  parameter int unsigned DEPTH         = DEFAULT_DEPTH,
  parameter int unsigned AFULL_THRESH  = DEPTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4,
  parameter int unsigned FWFT          = FIFO_STD
) (
  input logic              clk,
  input logic              rst_n,
  fifo_sync_flags_if.slave bus
);

  localparam int unsigned AW        = addr_width(DEPTH);
  localparam logic [AW:0] LvlFull   = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LvlAfull  = (AW + 1)'(AFULL_THRESH);
  localparam logic [AW:0] LvlAempty = (AW + 1)'(AEMPTY_THRESH);
  localparam logic [AW:0] LvlOne    = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;
  acc_e             acc;
  logic [WIDTH-1:0] mem_rdata;

  // Acceptance uses only registered flags, so no request reaches a flag combinationally.
  assign wr_acc = bus.wr_en && !full_q;
  assign rd_acc = bus.rd_en && !empty_q;
  assign acc    = acc_e'({wr_acc, rd_acc});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    unique case (acc)
      AccWrite: begin
        wr_ptr_d = wr_ptr_q + LvlOne;
        level_d  = level_q + LvlOne;
      end
      AccRead: begin
        rd_ptr_d = rd_ptr_q + LvlOne;
        level_d  = level_q - LvlOne;
      end
      AccBoth: begin
        wr_ptr_d = wr_ptr_q + LvlOne;
        rd_ptr_d = rd_ptr_q + LvlOne;
      end
      default: ;
    endcase

    full_d   = (level_d == LvlFull);
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= LvlAfull);
    aempty_d = (level_d <= LvlAempty);

    // A new error event outranks a coincident clear.
    ovf_d = (bus.wr_en && full_q)  ? 1'b1 : (bus.clr_err ? 1'b0 : ovf_q);
    unf_d = (bus.rd_en && empty_q) ? 1'b1 : (bus.clr_err ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q[AW-1:0]),
    .wdata_i(bus.wr_data),
    .raddr_i(rd_ptr_q[AW-1:0]),
    .rdata_o(mem_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // Head word is presented directly; forced to zero while empty so reset reads as 0.
    assign bus.rd_data  = empty_q ? '0 : mem_rdata;
    assign bus.rd_valid = !empty_q;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) begin
          rd_data_q <= mem_rdata;
        end
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule
